rx_pbm: RTL and testbench

//  Packet Buffer Manager directly downstream of the RX parser. Stores parser payload words in a

---
 rtl/rx_pbm.sv | 208 ++++++++++++++++++++
 tb/tb_rx_pbm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pbm.sv
// Packet buffer manager: stages parser words in a circular RAM and publishes them on commit.
// Committed packets replay on an AXI-Stream master. RX_PBM_STATS_EN enables the packet/drop counters.
module rx_pbm #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LQ_AW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wvalid,
  input  logic              i_wlast,
  input  logic              i_werror,
  input  logic              i_commit,
  output logic              o_wready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   o_free_words,
  output logic [31:0]       o_pkt_cnt,
  output logic [31:0]       o_drop_cnt
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned LQ_DEPTH = 1 << LQ_AW;
  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

  typedef logic [ADDR_W:0] ptr_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_q;
  ptr_t              lq_mem [LQ_DEPTH];

  ptr_t              wr_ptr, wr_base, rd_ptr, pkt_len, fetch_left, fetch_left_n;
  logic              ovf;
  logic [LQ_AW:0]    lq_wp, lq_rp;
  logic [ADDR_W-1:0] fetch_addr;
  rstate_t           state, state_n;

  logic              out_valid, out_last, skid_valid, skid_last, rd_pend, pend_last;
  logic [DATA_W-1:0] out_data, skid_data;

  logic unused_wlast;
  assign unused_wlast = i_wlast;

  // ---------------- write side ----------------
  ptr_t used, wr_ptr_eff, len_eff, lq_head;
  logic space, wr_en, ovf_eff, lq_full, lq_empty, commit_ok, rewind;

  assign o_wready   = ~rst;
  assign used       = wr_ptr - rd_ptr;
  assign space      = ~used[ADDR_W];
  assign wr_en      = i_wvalid & o_wready & space;
  assign wr_ptr_eff = wr_ptr + ptr_t'(wr_en);
  assign len_eff    = pkt_len + ptr_t'(wr_en);
  assign ovf_eff    = ovf | (i_wvalid & o_wready & ~space);
  assign lq_empty   = (lq_wp == lq_rp);
  assign lq_full    = (lq_wp[LQ_AW] != lq_rp[LQ_AW]) &&
                      (lq_wp[LQ_AW-1:0] == lq_rp[LQ_AW-1:0]);
  assign lq_head    = lq_mem[lq_rp[LQ_AW-1:0]];
  // A word arriving with the commit/rollback pulse is folded into the closing packet.
  assign commit_ok  = i_commit & ~i_werror & ~ovf_eff & (len_eff != '0) & ~lq_full;
  assign rewind     = i_werror | (i_commit & ~commit_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      wr_base <= '0;
      pkt_len <= '0;
      ovf     <= 1'b0;
      lq_wp   <= '0;
    end else begin
      wr_ptr <= rewind ? wr_base : wr_ptr_eff;
      if (commit_ok) wr_base <= wr_ptr_eff;
      if (i_commit | i_werror) begin
        pkt_len <= '0;
        ovf     <= 1'b0;
      end else begin
        pkt_len <= len_eff;
        ovf     <= ovf_eff;
      end
      lq_wp <= lq_wp + (LQ_AW+1)'(commit_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr[ADDR_W-1:0]] <= i_wdata;
    if (commit_ok) lq_mem[lq_wp[LQ_AW-1:0]] <= len_eff;
  end

  // ---------------- read side ----------------
  logic       pop, can_issue, rd_en, lq_pop, issue_last;
  logic [1:0] occ;

  assign pop = out_valid & m_axis_tready;
  assign occ = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend);
  // Output reg + skid give two slots; a read is issued only if its data is sure to find one.
  assign can_issue = (occ - 2'(pop)) <= 2'd1;

  always_comb begin
    state_n      = state;
    fetch_left_n = fetch_left;
    rd_en        = 1'b0;
    lq_pop       = 1'b0;
    issue_last   = 1'b0;
    case (state)
      R_IDLE: begin
        if (!lq_empty && can_issue) begin
          lq_pop       = 1'b1;
          rd_en        = 1'b1;
          issue_last   = (lq_head == ptr_t'(1));
          fetch_left_n = lq_head - ptr_t'(1);
          state_n      = (lq_head == ptr_t'(1)) ? R_IDLE : R_FETCH;
        end
      end
      R_FETCH, R_STREAM: begin
        if (can_issue) begin
          rd_en        = 1'b1;
          issue_last   = (fetch_left == ptr_t'(1));
          fetch_left_n = fetch_left - ptr_t'(1);
          state_n      = (fetch_left == ptr_t'(1)) ? R_IDLE : R_STREAM;
        end
      end
      default: state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= ram[fetch_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= R_IDLE;
      fetch_left <= '0;
      fetch_addr <= '0;
      lq_rp      <= '0;
      rd_ptr     <= '0;
      rd_pend    <= 1'b0;
      pend_last  <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else begin
      state      <= state_n;
      fetch_left <= fetch_left_n;
      fetch_addr <= fetch_addr + ADDR_W'(rd_en);
      lq_rp      <= lq_rp + (LQ_AW+1)'(lq_pop);
      rd_ptr     <= rd_ptr + ptr_t'(pop);
      rd_pend    <= rd_en;
      pend_last  <= issue_last;
      if (out_valid && !pop) begin
        if (!skid_valid) begin
          skid_valid <= rd_pend;
          skid_data  <= ram_q;
          skid_last  <= pend_last;
        end
      end else if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= rd_pend;
        skid_data  <= ram_q;
        skid_last  <= pend_last;
      end else begin
        out_valid <= rd_pend;
        out_last  <= rd_pend & pend_last;
        if (rd_pend) out_data <= ram_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_free_words <= DEPTH_P;
    else     o_free_words <= DEPTH_P - used;
  end

  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_last;

`ifdef RX_PBM_STATS_EN
  logic [31:0] pkt_cnt, drop_cnt;
  logic        drop_evt;
  assign drop_evt = i_werror | (i_commit & ~commit_ok & (ovf_eff | (len_eff != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      pkt_cnt  <= pkt_cnt + 32'(commit_ok);
      drop_cnt <= drop_cnt + 32'(drop_evt);
    end
  end
  assign o_pkt_cnt  = pkt_cnt;
  assign o_drop_cnt = drop_cnt;
`else
  assign o_pkt_cnt  = '0;
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_pbm.sv
// Directed bench for rx_pbm: table of single-packet cases plus hand sequences for
// rollback, overflow, back-to-back with backpressure, commit/error collision and reset.
module tb_rx_pbm;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LQ_AW  = 4;
`ifdef RX_PBM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int unsigned A_CMT = 0, A_ERR = 1, A_BOTH = 2, A_CMT_LAST = 3, A_ERR_LAST = 4;

  typedef struct {
    int unsigned n;
    logic [31:0] base;
    int unsigned act;
    int unsigned exp_beats;
    int unsigned exp_pkt;
    int unsigned exp_drop;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] i_wdata = '0;
  logic              i_wvalid = 1'b0, i_wlast = 1'b0, i_werror = 1'b0, i_commit = 1'b0;
  logic              o_wready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tlast;
  logic              m_axis_tready = 1'b0;
  logic [ADDR_W:0]   o_free_words;
  logic [31:0]       o_pkt_cnt, o_drop_cnt;

  int unsigned n_checks = 0, n_err = 0;
  int unsigned exp_pkt = 0, exp_drop = 0;

  always #5 clk = ~clk;

  rx_pbm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LQ_AW(LQ_AW)) dut (
    .clk(clk), .rst(rst),
    .i_wdata(i_wdata), .i_wvalid(i_wvalid), .i_wlast(i_wlast),
    .i_werror(i_werror), .i_commit(i_commit), .o_wready(o_wready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .o_free_words(o_free_words), .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_pkt_cnt"}, o_pkt_cnt, STATS ? exp_pkt : 32'd0);
    chk({tag, "_drop_cnt"}, o_drop_cnt, STATS ? exp_drop : 32'd0);
  endtask

  task automatic write_words(input int unsigned n, input logic [31:0] base);
    for (int unsigned i = 0; i < n; i++) begin
      i_wdata  = base + i;
      i_wvalid = 1'b1;
      i_wlast  = (i == n - 1);
      step();
    end
    i_wvalid = 1'b0;
    i_wlast  = 1'b0;
  endtask

  task automatic pulse(input logic c, input logic e);
    i_commit = c;
    i_werror = e;
    step();
    i_commit = 1'b0;
    i_werror = 1'b0;
  endtask

  // Accept beats until exp_n seen (plus a tail to catch extras); tlast expected on beat exp_n and on beat split.
  task automatic drain(input int unsigned exp_n, input logic [31:0] base, input bit toggle,
                       input int unsigned split, input string tag);
    int unsigned got = 0, cyc = 0, extra = 0, bad = 0;
    logic [31:0] hold_d = '0;
    logic        hold_l = 1'b0;
    bit          holding = 1'b0;
    while (cyc < 3000 && extra < 6) begin
      m_axis_tready = toggle ? cyc[0] : 1'b1;
      if (m_axis_tvalid) begin
        if (holding && (m_axis_tdata !== hold_d || m_axis_tlast !== hold_l)) bad++;
        if (m_axis_tready) begin
          if (m_axis_tdata !== base + got) bad++;
          if (m_axis_tlast !== ((got + 1 == exp_n) || (got + 1 == split))) bad++;
          got++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          hold_d  = m_axis_tdata;
          hold_l  = m_axis_tlast;
        end
      end else if (holding) begin
        bad++;
      end
      if (got >= exp_n) extra++;
      step();
      cyc++;
    end
    m_axis_tready = 1'b1;
    chk({tag, "_beats"}, got, exp_n);
    chk({tag, "_beat_errs"}, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{5, 32'hA0,  A_CMT,      5, 1, 0};
    vecs[1] = '{1, 32'h100, A_CMT,      1, 1, 0};
    vecs[2] = '{0, 32'h0,   A_CMT,      0, 0, 0};
    vecs[3] = '{4, 32'h200, A_ERR,      0, 0, 1};
    vecs[4] = '{3, 32'h300, A_BOTH,     0, 0, 1};
    vecs[5] = '{3, 32'h400, A_CMT_LAST, 3, 1, 0};
    vecs[6] = '{2, 32'h500, A_ERR_LAST, 0, 0, 1};
    vecs[7] = '{6, 32'h600, A_CMT,      6, 1, 0};

    #2 rst = 1'b1;
    step();
    step();
    chk("rst_wready", o_wready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_free", o_free_words, 1024);
    chk_stats("rst");
    rst = 1'b0;
    #1;
    chk("wready_after_rst", o_wready, 1);
    step();
    m_axis_tready = 1'b1;

    foreach (vecs[k]) begin
      vec_t v;
      string tag;
      v   = vecs[k];
      tag = $sformatf("v%0d", k);
      if (v.act == A_CMT_LAST || v.act == A_ERR_LAST) begin
        for (int unsigned i = 0; i < v.n; i++) begin
          i_wdata  = v.base + i;
          i_wvalid = 1'b1;
          i_wlast  = (i == v.n - 1);
          if (i == v.n - 1) begin
            i_commit = (v.act == A_CMT_LAST);
            i_werror = (v.act == A_ERR_LAST);
          end
          step();
        end
        i_wvalid = 1'b0; i_wlast = 1'b0; i_commit = 1'b0; i_werror = 1'b0;
      end else begin
        write_words(v.n, v.base);
        pulse(v.act == A_CMT || v.act == A_BOTH, v.act == A_ERR || v.act == A_BOTH);
      end
      if (v.exp_beats != 0) begin
        chk({tag, "_lat0"}, m_axis_tvalid, 0);
        step();
        chk({tag, "_lat1"}, m_axis_tvalid, 0);
        step();
        chk({tag, "_lat2"}, m_axis_tvalid, 1);
      end
      drain(v.exp_beats, v.base, 1'b0, 0, tag);
      chk({tag, "_free"}, o_free_words, 1024);
      exp_pkt  += v.exp_pkt;
      exp_drop += v.exp_drop;
      chk_stats(tag);
    end

    // rollback then a fresh packet
    write_words(3, 32'hC0);
    pulse(1'b0, 1'b1);
    write_words(2, 32'hB0);
    pulse(1'b1, 1'b0);
    drain(2, 32'hB0, 1'b0, 0, "t2");
    chk("t2_free", o_free_words, 1024);
    exp_drop++; exp_pkt++;
    chk_stats("t2");

    // fill to 1023 under backpressure, then an overflowing packet
    m_axis_tready = 1'b0;
    write_words(1023, 32'h0);
    pulse(1'b1, 1'b0);
    write_words(4, 32'h5000);
    pulse(1'b1, 1'b0);
    step();
    step();
    chk("t3_free", o_free_words, 1);
    chk("t3_tvalid_stalled", m_axis_tvalid, 1);
    chk("t3_tdata_stalled", m_axis_tdata, 0);
    exp_pkt++; exp_drop++;
    chk_stats("t3");
    drain(1023, 32'h0, 1'b0, 0, "t3");
    chk("t3_free_drained", o_free_words, 1024);

    // two packets back-to-back, tready toggling
    m_axis_tready = 1'b0;
    write_words(2, 32'hC0);
    pulse(1'b1, 1'b0);
    write_words(3, 32'hC2);
    pulse(1'b1, 1'b0);
    drain(5, 32'hC0, 1'b1, 2, "t4");
    exp_pkt += 2;
    chk_stats("t4");

    // commit and rollback in one cycle
    write_words(2, 32'hD0);
    pulse(1'b1, 1'b1);
    drain(0, 32'h0, 1'b0, 0, "t5");
    chk("t5_free", o_free_words, 1024);
    exp_drop++;
    chk_stats("t5");

    // reset while a beat is pending
    m_axis_tready = 1'b0;
    write_words(8, 32'hE0);
    pulse(1'b1, 1'b0);
    for (int unsigned w = 0; w < 20 && !m_axis_tvalid; w++) step();
    chk("t6_valid_before_rst", m_axis_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_free", o_free_words, 1024);
    chk("t6_rst_wready", o_wready, 0);
    step();
    step();
    rst = 1'b0;
    exp_pkt = 0; exp_drop = 0;
    chk_stats("t6_rst");
    step();
    m_axis_tready = 1'b1;
    write_words(3, 32'hF0);
    pulse(1'b1, 1'b0);
    drain(3, 32'hF0, 1'b0, 0, "t6");
    chk("t6_free", o_free_words, 1024);
    exp_pkt = 1;
    chk_stats("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
